// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice datapath: default word width and sweep FSM encoding.
package synth_pkg;
  localparam int FREQ_W_DEF = 24;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_SWEEP = 1'b1;
endpackage

// File: rtl/glide_step.sv
// One glide step toward the target; purely combinational, zero latency.
// Sum/difference carry one extra bit so an overshoot clamps to tgt instead of wrapping.
module glide_step #(
  parameter int FREQ_W = synth_pkg::FREQ_W_DEF
) (
  input  logic [FREQ_W-1:0] cur,
  input  logic [FREQ_W-1:0] tgt,
  input  logic [FREQ_W-1:0] rate,
  output logic [FREQ_W-1:0] next
);
  logic [FREQ_W:0] w_sum;
  logic [FREQ_W:0] w_diff;

  assign w_sum  = {1'b0, cur} + {1'b0, rate};
  assign w_diff = {1'b0, cur} - {1'b0, rate};

  always_comb begin
    next = cur;
    if (cur < tgt) begin
      next = (w_sum < {1'b0, tgt}) ? w_sum[FREQ_W-1:0] : tgt;
    end else if (cur > tgt) begin
      // w_diff[FREQ_W] set means the subtraction borrowed past zero
      next = (!w_diff[FREQ_W] && (w_diff[FREQ_W-1:0] > tgt)) ? w_diff[FREQ_W-1:0] : tgt;
    end
  end
endmodule

// File: rtl/glide_sched.sv
// Time-shares one glide_step across NUM_VOICES voices, one voice per cycle after each sample tick.
// Results are registered (1 cycle after processing); notes are held off while a sweep runs or a tick is pending.
module glide_sched
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int FREQ_W     = FREQ_W_DEF
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          sample_tick,
  input  logic [FREQ_W-1:0]             rate,
  input  logic                          note_valid,
  output logic                          note_ready,
  input  logic [$clog2(NUM_VOICES)-1:0] note_voice,
  input  logic [FREQ_W-1:0]             note_freq,
  input  logic                          note_legato,
  output logic [FREQ_W-1:0]             freq_out,
  output logic [$clog2(NUM_VOICES)-1:0] freq_voice,
  output logic                          freq_valid,
  output logic                          overrun
);
  localparam int VW = $clog2(NUM_VOICES);
  localparam logic [VW-1:0] LAST_VOICE = VW'(NUM_VOICES - 1);

  logic [FREQ_W-1:0] r_cur [NUM_VOICES];
  logic [FREQ_W-1:0] r_tgt [NUM_VOICES];
  state_t            r_state;
  logic [VW-1:0]     r_idx;
  logic              r_pend;
  logic              r_overrun;
  logic              r_freq_valid;
  logic [FREQ_W-1:0] r_freq_out;
  logic [VW-1:0]     r_freq_voice;

  logic              w_note_acc;
  logic [FREQ_W-1:0] w_next;

  assign note_ready = !RESET && (r_state == ST_IDLE) && !r_pend;
  assign w_note_acc = note_valid && note_ready;

  glide_step #(.FREQ_W(FREQ_W)) u_step (
    .cur  (r_cur[r_idx]),
    .tgt  (r_tgt[r_idx]),
    .rate (rate),
    .next (w_next)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_pend       <= 1'b0;
      r_overrun    <= 1'b0;
      r_freq_valid <= 1'b0;
      r_freq_out   <= '0;
      r_freq_voice <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_cur[v] <= '0;
        r_tgt[v] <= '0;
      end
    end else begin
      r_freq_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_note_acc) begin
            r_tgt[note_voice] <= note_freq;
            if (!note_legato) r_cur[note_voice] <= note_freq;
          end
          if (sample_tick || r_pend) begin
            r_state <= ST_SWEEP;
            r_idx   <= '0;
            // a pending tick is consumed here; a fresh tick in the same cycle takes its place
            r_pend  <= sample_tick && r_pend;
          end
        end
        ST_SWEEP: begin
          r_cur[r_idx] <= w_next;
          r_freq_valid <= 1'b1;
          r_freq_out   <= w_next;
          r_freq_voice <= r_idx;
          r_idx        <= r_idx + 1'b1;
          if (r_idx == LAST_VOICE) r_state <= ST_IDLE;
          if (sample_tick) begin
            if (r_pend) r_overrun <= 1'b1;
            else        r_pend    <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign freq_valid = r_freq_valid;
  assign freq_out   = r_freq_out;
  assign freq_voice = r_freq_voice;
  assign overrun    = r_overrun;
endmodule

// File: tb/tb_glide_sched.sv
// Directed and randomized checks of glide_sched against a per-voice arithmetic model.
module tb_glide_sched;
  localparam int NV = 4;
  localparam int W  = 24;

  logic          CLK;
  logic          RESET;
  logic          sample_tick;
  logic [W-1:0]  rate;
  logic          note_valid;
  logic          note_ready;
  logic [1:0]    note_voice;
  logic [W-1:0]  note_freq;
  logic          note_legato;
  logic [W-1:0]  freq_out;
  logic [1:0]    freq_voice;
  logic          freq_valid;
  logic          overrun;

  int n_pass  = 0;
  int n_total = 0;

  longint       m_cur [NV];
  longint       m_tgt [NV];
  logic [W-1:0] got   [NV];

  glide_sched #(.NUM_VOICES(NV), .FREQ_W(W)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .sample_tick (sample_tick),
    .rate        (rate),
    .note_valid  (note_valid),
    .note_ready  (note_ready),
    .note_voice  (note_voice),
    .note_freq   (note_freq),
    .note_legato (note_legato),
    .freq_out    (freq_out),
    .freq_voice  (freq_voice),
    .freq_valid  (freq_valid),
    .overrun     (overrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Glide rule on unbounded integers: approach target by rate, never pass it.
  function automatic longint mstep(input longint c, input longint t, input longint r);
    if (c < t) return (c + r < t) ? c + r : t;
    if (c > t) return (c - r > t) ? c - r : t;
    return c;
  endfunction

  function automatic void model_reset();
    for (int v = 0; v < NV; v++) begin
      m_cur[v] = 0;
      m_tgt[v] = 0;
    end
  endfunction

  function automatic void model_note(input int v, input longint f, input bit leg);
    m_tgt[v] = f;
    if (!leg) m_cur[v] = f;
  endfunction

  task automatic apply_note(input int v, input longint f, input bit leg);
    note_valid  = 1'b1;
    note_voice  = v[1:0];
    note_freq   = f[W-1:0];
    note_legato = leg;
    chk("note_ready_idle", 32'(note_ready), 1);
    model_note(v, f, leg);
    step();
    note_valid = 1'b0;
  endtask

  // Tick from IDLE (optionally with a coincident note), then check the full sweep schedule.
  task automatic run_tick(input bit nv, input int nvc, input longint nf, input bit nl);
    longint e [NV];
    sample_tick = 1'b1;
    if (nv) begin
      note_valid  = 1'b1;
      note_voice  = nvc[1:0];
      note_freq   = nf[W-1:0];
      note_legato = nl;
      chk("tick_note_ready", 32'(note_ready), 1);
      model_note(nvc, nf, nl);
    end
    for (int v = 0; v < NV; v++) begin
      e[v] = mstep(m_cur[v], m_tgt[v], longint'(rate));
      m_cur[v] = e[v];
    end
    step();
    sample_tick = 1'b0;
    note_valid  = 1'b0;
    for (int k = 0; k < NV; k++) begin
      chk("sweep_note_ready", 32'(note_ready), 0);
      step();
      chk("sweep_valid", 32'(freq_valid), 1);
      chk("sweep_voice", 32'(freq_voice), k);
      chk("sweep_freq", 32'(freq_out), 32'(e[k]));
      got[k] = freq_out;
    end
    chk("post_note_ready", 32'(note_ready), 1);
    step();
    chk("post_valid_low", 32'(freq_valid), 0);
  endtask

  initial begin
    longint e1 [NV];
    longint e2 [NV];
    int     nn;

    RESET = 1'b1; sample_tick = 1'b0; rate = '0;
    note_valid = 1'b0; note_voice = '0; note_freq = '0; note_legato = 1'b0;
    model_reset();
    step();
    step();
    chk("rst_valid", 32'(freq_valid), 0);
    chk("rst_freq", 32'(freq_out), 0);
    chk("rst_voice", 32'(freq_voice), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_note_ready", 32'(note_ready), 0);
    RESET = 1'b0;
    step();
    chk("idle_note_ready", 32'(note_ready), 1);
    chk("idle_valid", 32'(freq_valid), 0);

    // glide up on voice 1
    rate = 24'd10;
    apply_note(1, 1000, 1'b0);
    apply_note(1, 1030, 1'b1);
    run_tick(0, 0, 0, 0); chk("glide_1", 32'(got[1]), 1010);
    run_tick(0, 0, 0, 0); chk("glide_2", 32'(got[1]), 1020);
    run_tick(0, 0, 0, 0); chk("glide_3", 32'(got[1]), 1030);
    run_tick(0, 0, 0, 0); chk("glide_4", 32'(got[1]), 1030);

    // rate 0 freezes motion
    rate = '0;
    apply_note(1, 2000, 1'b1);
    run_tick(0, 0, 0, 0); chk("rate0_hold", 32'(got[1]), 1030);

    // saturation at the top of the range
    rate = 24'h100;
    apply_note(0, 24'hFFFFF0, 1'b0);
    apply_note(0, 24'hFFFFFF, 1'b1);
    run_tick(0, 0, 0, 0); chk("sat_up", 32'(got[0]), 32'hFFFFFF);

    // underflow clamps to target
    rate = 24'd10;
    apply_note(3, 5, 1'b0);
    apply_note(3, 0, 1'b1);
    run_tick(0, 0, 0, 0); chk("sat_down", 32'(got[3]), 0);

    // jump
    apply_note(2, 5000, 1'b0);
    run_tick(0, 0, 0, 0); chk("jump", 32'(got[2]), 5000);

    // note coincident with tick is written before the sweep
    run_tick(1, 2, 777, 0); chk("coincide", 32'(got[2]), 777);

    // overrun: ticks at T, T+2, T+3
    rate = 24'd7;
    apply_note(0, 100, 1'b1);
    apply_note(3, 50, 1'b1);
    chk("ovr_before", 32'(overrun), 0);
    for (int v = 0; v < NV; v++) e1[v] = mstep(m_cur[v], m_tgt[v], 7);
    for (int v = 0; v < NV; v++) e2[v] = mstep(e1[v], m_tgt[v], 7);
    for (int v = 0; v < NV; v++) m_cur[v] = e2[v];
    sample_tick = 1'b1;
    step();
    for (int o = 1; o <= 12; o++) begin
      sample_tick = (o == 2 || o == 3);
      chk("ovr_flag", 32'(overrun), (o >= 4) ? 1 : 0);
      if (o >= 2 && o <= 5) begin
        chk("ovr_s1_valid", 32'(freq_valid), 1);
        chk("ovr_s1_voice", 32'(freq_voice), o - 2);
        chk("ovr_s1_freq", 32'(freq_out), 32'(e1[o-2]));
      end else if (o >= 7 && o <= 10) begin
        chk("ovr_s2_valid", 32'(freq_valid), 1);
        chk("ovr_s2_voice", 32'(freq_voice), o - 7);
        chk("ovr_s2_freq", 32'(freq_out), 32'(e2[o-7]));
      end else begin
        chk("ovr_gap_valid", 32'(freq_valid), 0);
      end
      step();
    end
    sample_tick = 1'b0;
    run_tick(0, 0, 0, 0);
    chk("ovr_sticky", 32'(overrun), 1);

    // reset in the middle of a sweep
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    chk("mid_v0_valid", 32'(freq_valid), 1);
    step();
    chk("mid_v1_voice", 32'(freq_voice), 1);
    RESET = 1'b1;
    step();
    chk("mid_rst_valid", 32'(freq_valid), 0);
    chk("mid_rst_freq", 32'(freq_out), 0);
    chk("mid_rst_voice", 32'(freq_voice), 0);
    chk("mid_rst_overrun", 32'(overrun), 0);
    chk("mid_rst_ready", 32'(note_ready), 0);
    RESET = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mid_quiet", 32'(freq_valid), 0);
    end
    rate = 24'd50;
    run_tick(0, 0, 0, 0);
    for (int v = 0; v < NV; v++) chk("mid_zero", 32'(got[v]), 0);

    // randomized notes, rates and coincident writes
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0: rate = '0;
        1: rate = W'($urandom_range(1, 100));
        2: rate = W'($urandom_range(0, 32'hFFFFFF));
        default: rate = 24'hFFFFFF;
      endcase
      nn = int'($urandom_range(0, 2));
      for (int j = 0; j < nn; j++)
        apply_note(int'($urandom_range(0, NV - 1)),
                   longint'($urandom_range(0, 32'hFFFFFF)), 1'($urandom_range(0, 1)));
      run_tick(1'($urandom_range(0, 1)), int'($urandom_range(0, NV - 1)),
               longint'($urandom_range(0, 32'hFFFFFF)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
